// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the 1x3 router input port (header, payload, parity)
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake, cmd_addr (0..2) and cmd_len (1..63)
//   pl_valid/pl_ready/pl_data  payload byte stream
//   busy, hold                 router flow control (header gate, payload/parity stall)
//   data_out, pkt_valid        byte stream to router data_in
//   pkt_done                   pulse in the parity cycle
//   cmd_err                    pulse when a command is dropped (addr==3 or len==0)
//   underrun                   sticky, payload starved while owed
//   tx_pkt_cnt                 completed packet count, wraps
//   err_inj                    only with PARITY_ERR_INJ_EN: invert parity of the accepted packet
module router_pkt_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 6,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  pl_valid,
   input  logic [DATA_WIDTH-1:0] pl_data,
   output logic                  pl_ready,
   input  logic                  busy,
   input  logic                  hold,
`ifdef PARITY_ERR_INJ_EN
   input  logic                  err_inj,
`endif
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  pkt_valid,
   output logic                  pkt_done,
   output logic                  cmd_err,
   output logic                  underrun,
   output logic [CNT_WIDTH-1:0]  tx_pkt_cnt
);
   typedef enum logic [2:0] {IDLE, WAIT_BUSY, HEADER, PAYLOAD, PARITY, GAP} state_t;
   state_t                state_q;
   logic [1:0]            addr_q;
   logic [LEN_WIDTH-1:0]  len_q, cnt_q;
   logic [DATA_WIDTH-1:0] data_q, acc_q, hdr, par_d;
   logic                  pv_q, done_q, err_q, und_q;
   logic [CNT_WIDTH-1:0]  tx_q;
   logic                  legal;
   assign legal = (cmd_addr != 2'd3) && (cmd_len != '0);
   assign hdr = DATA_WIDTH'({len_q, addr_q});
`ifdef PARITY_ERR_INJ_EN
   logic inj_q;
   assign par_d = inj_q ? ~acc_q : acc_q;
`else
   assign par_d = acc_q;
`endif
   assign cmd_ready  = (state_q == IDLE);
   assign pl_ready   = (state_q == PAYLOAD) && !hold;
   assign data_out   = data_q;
   assign pkt_valid  = pv_q;
   assign pkt_done   = done_q;
   assign cmd_err    = err_q;
   assign underrun   = und_q;
   assign tx_pkt_cnt = tx_q;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         acc_q   <= '0;
         pv_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         und_q   <= 1'b0;
         tx_q    <= '0;
`ifdef PARITY_ERR_INJ_EN
         inj_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: if (cmd_valid) begin
               if (legal) begin
                  addr_q  <= cmd_addr;
                  len_q   <= cmd_len;
`ifdef PARITY_ERR_INJ_EN
                  inj_q   <= err_inj;
`endif
                  state_q <= WAIT_BUSY;
               end else begin
                  err_q <= 1'b1;
               end
            end
            WAIT_BUSY: if (!busy) begin
               data_q  <= hdr;
               acc_q   <= hdr;
               pv_q    <= 1'b1;
               cnt_q   <= '0;
               state_q <= HEADER;
            end
            HEADER: state_q <= PAYLOAD;
            PAYLOAD: if (!hold) begin
               if (pl_valid) begin
                  data_q <= pl_data;
                  acc_q  <= acc_q ^ pl_data;
                  pv_q   <= 1'b1;
                  cnt_q  <= cnt_q + 1'b1;
                  if (cnt_q + 1'b1 == len_q) state_q <= PARITY;
               end else begin
                  und_q <= 1'b1;
               end
            end
            PARITY: if (!hold) begin
               data_q  <= par_d;
               pv_q    <= 1'b0;
               done_q  <= 1'b1;
               tx_q    <= tx_q + 1'b1;
               state_q <= GAP;
            end
            GAP: begin
               data_q  <= '0;
               pv_q    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed scoreboard bench for router_pkt_tx
module tb_router_pkt_tx;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready;
   logic [1:0] cmd_addr = '0;
   logic [5:0] cmd_len = '0;
   logic       pl_valid = 1'b0, pl_ready;
   logic [7:0] pl_data = '0;
   logic       busy = 1'b0, hold = 1'b0;
   logic [7:0] data_out;
   logic       pkt_valid, pkt_done, cmd_err, underrun;
   logic [15:0] tx_pkt_cnt;
   int checks = 0, errors = 0, errcnt = 0, pvrise = 0;
   logic [7:0] plq[$], expq[$];
   logic       cmdv = 1'b0;
   logic [1:0] ca = '0;
   logic [5:0] cl = '0;
   logic [7:0] save;
   int         k;
   router_pkt_tx dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .pl_valid(pl_valid), .pl_data(pl_data),
      .pl_ready(pl_ready), .busy(busy), .hold(hold), .data_out(data_out),
      .pkt_valid(pkt_valid), .pkt_done(pkt_done), .cmd_err(cmd_err),
      .underrun(underrun), .tx_pkt_cnt(tx_pkt_cnt)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic pop_chk(input string tag, input logic [7:0] obs);
      if (expq.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed %0h expected nothing (queue empty)", tag, obs);
      end else check(tag, obs, expq.pop_front());
   endtask
   // one clock: drive at negedge, resolve handshakes just before posedge, return 1 after posedge
   task automatic tick(input bit h = 0, input bit b = 0, input bit g = 0, input bit r = 1);
      bit cf, pf;
      @(negedge clk);
      rstn = r; hold = h; busy = b;
      cmd_valid = cmdv; cmd_addr = ca; cmd_len = cl;
      pl_valid = (plq.size() != 0) && !g;
      pl_data = (plq.size() != 0) ? plq[0] : 8'h00;
      #4;
      cf = cmd_valid && cmd_ready;
      pf = pl_valid && pl_ready;
      @(posedge clk);
      if (cf && rstn) cmdv = 1'b0;
      if (pf && rstn) void'(plq.pop_front());
      #1;
   endtask
   task automatic send(input logic [1:0] a, input logic [5:0] len, input logic [7:0] seed, input logic [7:0] step);
      logic [7:0] p, d;
      cmdv = 1'b1; ca = a; cl = len;
      p = {len, a};
      expq.push_back(p);
      for (int i = 0; i < len; i++) begin
         d = seed + 8'(i) * step;
         plq.push_back(d);
         expq.push_back(d);
         p = p ^ d;
      end
      expq.push_back(p);
   endtask
   task automatic wait_cnt(input int tgt, input int budget);
      int n = 0;
      while (!(tx_pkt_cnt == 16'(tgt) && cmd_ready && plq.size() == 0 && !cmdv) && n < budget) begin
         tick();
         n++;
      end
      check("packet_timeout", n < budget, 1);
      check("tx_pkt_cnt", tx_pkt_cnt, tgt);
      check("exp_queue_drained", expq.size(), 0);
   endtask
   // monitor: scoreboard pops on header launch, accepted payload byte, and parity
   always begin : mon
      bit f, rs, pv_prev;
      @(negedge clk);
      #4;
      f = pl_valid && pl_ready;
      rs = rstn;
      @(posedge clk);
      #1;
      if (rs) begin
         if (f) begin
            pop_chk("payload_byte", data_out);
            check("payload_pkt_valid", pkt_valid, 1);
         end else if (pkt_valid && !pv_prev) begin
            pop_chk("header_byte", data_out);
            pvrise++;
         end
         if (pkt_done) begin
            pop_chk("parity_byte", data_out);
            check("parity_pkt_valid", pkt_valid, 0);
         end
         if (cmd_err) errcnt++;
      end
      pv_prev = pkt_valid;
   end
   initial begin
      tick(.r(0));
      tick(.r(0));
      check("rst_data_out", data_out, 0);
      check("rst_pkt_valid", pkt_valid, 0);
      check("rst_pkt_done", pkt_done, 0);
      check("rst_cmd_err", cmd_err, 0);
      check("rst_underrun", underrun, 0);
      check("rst_tx_cnt", tx_pkt_cnt, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_pl_ready", pl_ready, 0);
      // basic packet: 0x0D 11 22 33 0D
      send(2'd1, 6'd3, 8'h11, 8'h11);
      check("basic_exp_parity", expq[4], 8'h0D);
      wait_cnt(1, 40);
      // illegal commands
      k = pvrise;
      cmdv = 1'b1; ca = 2'd3; cl = 6'd4;
      tick();
      check("ill_addr_cmd_err", cmd_err, 1);
      check("ill_addr_cmd_ready", cmd_ready, 1);
      tick();
      check("ill_pulse_width", cmd_err, 0);
      cmdv = 1'b1; ca = 2'd0; cl = 6'd0;
      tick();
      check("ill_len_cmd_err", cmd_err, 1);
      check("ill_len_cmd_ready", cmd_ready, 1);
      tick();
      tick();
      check("ill_err_count", errcnt, 2);
      check("ill_no_pkt", pvrise, k);
      check("ill_pkt_valid", pkt_valid, 0);
      // busy holds off the header
      send(2'd2, 6'd4, 8'h40, 8'h03);
      tick(.b(1));
      repeat (5) begin
         tick(.b(1));
         check("busy_no_header", pkt_valid, 0);
      end
      tick();
      check("busy_header_valid", pkt_valid, 1);
      check("busy_header_byte", data_out, 8'h12);
      wait_cnt(2, 40);
      // hold after 2nd payload byte, with pl_valid low too
      send(2'd0, 6'd5, 8'hA0, 8'h01);
      k = 0;
      while (plq.size() > 3 && k < 20) begin tick(); k++; end
      check("hold_reach", k < 20, 1);
      save = data_out;
      check("hold_second_byte", save, 8'hA1);
      repeat (3) begin
         tick(.h(1), .g(1));
         check("hold_data_frozen", data_out, save);
         check("hold_pkt_valid", pkt_valid, 1);
         check("hold_pl_ready", pl_ready, 0);
      end
      check("hold_no_underrun", underrun, 0);
      wait_cnt(3, 40);
      // payload starvation
      send(2'd1, 6'd4, 8'h70, 8'h05);
      k = 0;
      while (plq.size() > 3 && k < 20) begin tick(); k++; end
      check("gap_reach", k < 20, 1);
      check("gap_pre_underrun", underrun, 0);
      save = data_out;
      repeat (2) begin
         tick(.g(1));
         check("gap_data_frozen", data_out, save);
      end
      check("gap_underrun", underrun, 1);
      wait_cnt(4, 40);
      check("gap_underrun_sticky", underrun, 1);
      // maximum length
      send(2'd0, 6'd63, 8'h01, 8'h07);
      wait_cnt(5, 200);
      // reset mid-payload
      send(2'd2, 6'd6, 8'h30, 8'h09);
      k = 0;
      while (plq.size() > 4 && k < 20) begin tick(); k++; end
      check("mid_reach", k < 20, 1);
      tick(.r(0));
      plq.delete();
      expq.delete();
      cmdv = 1'b0;
      check("mid_rst_data_out", data_out, 0);
      check("mid_rst_pkt_valid", pkt_valid, 0);
      check("mid_rst_pkt_done", pkt_done, 0);
      check("mid_rst_underrun", underrun, 0);
      check("mid_rst_cnt", tx_pkt_cnt, 0);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      tick();
      tick();
      check("mid_no_parity", pkt_done, 0);
      send(2'd2, 6'd2, 8'h5A, 8'h4B);
      wait_cnt(1, 40);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
